cargador_mascara: RTL and testbench

CARGADOR_MASCARA -- requirements
Module: cargador_mascara

---
 rtl/cargador_mascara_if.sv | 32 +++
 rtl/cargador_mascara.sv | 131 +++++++++++++
 tb/tb_cargador_mascara.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cargador_mascara_if.sv
// Bus between the mask-coefficient loader, the coefficient memory and the
// coefficient bank. The loader connects through the slave modport; the
// environment that drives the start and memory side uses the master modport.
interface cargador_mascara_if #(
   parameter int BITS_DIRECCION_MEM = 10,
   parameter int BITS_MASCARA       = 3,
   parameter int BITS_DATOS         = 8
);
   logic                          iniciar_carga;
   logic [BITS_DIRECCION_MEM-1:0] direccion_mem_inicio_mascara;
   logic [BITS_MASCARA-1:0]       tamano_mascara;
   logic                          habilitacion_lectura_mem;
   logic [BITS_DIRECCION_MEM-1:0] direccion_lectura_mem;
   logic [BITS_DATOS-1:0]         datos_mem;
   logic                          escritura_coeficiente;
   logic [4:0]                    direccion_coeficiente;
   logic [BITS_DATOS-1:0]         dato_coeficiente;
   logic                          ocupado;
   logic                          carga_completa;

   modport slave (
      input  iniciar_carga, direccion_mem_inicio_mascara, tamano_mascara, datos_mem,
      output habilitacion_lectura_mem, direccion_lectura_mem, escritura_coeficiente,
             direccion_coeficiente, dato_coeficiente, ocupado, carga_completa
   );

   modport master (
      output iniciar_carga, direccion_mem_inicio_mascara, tamano_mascara, datos_mem,
      input  habilitacion_lectura_mem, direccion_lectura_mem, escritura_coeficiente,
             direccion_coeficiente, dato_coeficiente, ocupado, carga_completa
   );
endinterface

// File: rtl/cargador_mascara.sv
// Mask coefficient loader: on a start request with a 3x3 or 5x5 mask, reads
// size*size consecutive coefficients from memory (address wraps) and writes
// them row-major into the coefficient bank, then pulses carga_completa.
// Optional feature macro: CARGADOR_MASCARA_SUMA_EN adds suma_coeficientes,
// the running unsigned sum of the coefficients written by the current load.
module cargador_mascara #(
   parameter int BITS_DIRECCION_MEM = 10,
   parameter int BITS_MASCARA       = 3,
   parameter int BITS_DATOS         = 8
) (
   input  logic clk,
   input  logic reset,
   cargador_mascara_if.slave bus
`ifdef CARGADOR_MASCARA_SUMA_EN
   ,
   output logic [BITS_DATOS+4:0] suma_coeficientes
`endif
);

   typedef enum logic [1:0] {REPOSO, LECTURA, VACIADO, FIN} estado_t;

   estado_t                       estado_q, estado_d;
   logic [4:0]                    cont_q, cont_d;
   logic [4:0]                    num_q, num_d;
   logic [BITS_DIRECCION_MEM-1:0] base_q, base_d;
   logic                          escritura_q, escritura_d;
   logic [4:0]                    dir_coef_q, dir_coef_d;
   logic                          lee;
   logic [BITS_DIRECCION_MEM-1:0] dir_lectura;
   logic                          ocupado;
   logic                          completa;
   logic                          inicio_ok;
   logic                          tamano_legal;

   assign tamano_legal = (bus.tamano_mascara == BITS_MASCARA'(3)) ||
                         (bus.tamano_mascara == BITS_MASCARA'(5));

   // State, counter and write-side registers; reset clears everything so outputs drop at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q    <= REPOSO;
         cont_q      <= '0;
         num_q       <= '0;
         base_q      <= '0;
         escritura_q <= 1'b0;
         dir_coef_q  <= '0;
      end else begin
         estado_q    <= estado_d;
         cont_q      <= cont_d;
         num_q       <= num_d;
         base_q      <= base_d;
         escritura_q <= escritura_d;
         dir_coef_q  <= dir_coef_d;
      end
   end

   // Next-state and read-side outputs; a write lags its read by one cycle (memory latency)
   always_comb begin
      estado_d    = estado_q;
      cont_d      = cont_q;
      num_d       = num_q;
      base_d      = base_q;
      lee         = 1'b0;
      dir_lectura = '0;
      ocupado     = 1'b0;
      completa    = 1'b0;
      inicio_ok   = 1'b0;
      unique case (estado_q)
         REPOSO: begin
            if (bus.iniciar_carga && tamano_legal) begin
               base_d    = bus.direccion_mem_inicio_mascara;
               num_d     = (bus.tamano_mascara == BITS_MASCARA'(5)) ? 5'd25 : 5'd9;
               cont_d    = '0;
               inicio_ok = 1'b1;
               estado_d  = LECTURA;
            end
         end
         LECTURA: begin
            lee         = 1'b1;
            ocupado     = 1'b1;
            dir_lectura = base_q + BITS_DIRECCION_MEM'(cont_q);
            cont_d      = cont_q + 5'd1;
            if (cont_q == num_q - 5'd1) begin
               cont_d   = '0;
               estado_d = VACIADO;
            end
         end
         VACIADO: begin
            ocupado  = 1'b1;
            estado_d = FIN;
         end
         FIN: begin
            completa = 1'b1;
            estado_d = REPOSO;
         end
         default: estado_d = REPOSO;
      endcase
      escritura_d = lee;
      dir_coef_d  = lee ? cont_q : 5'd0;
   end

   assign bus.habilitacion_lectura_mem = lee;
   assign bus.direccion_lectura_mem    = dir_lectura;
   assign bus.escritura_coeficiente    = escritura_q;
   assign bus.direccion_coeficiente    = dir_coef_q;
   assign bus.dato_coeficiente         = escritura_q ? bus.datos_mem : '0;
   assign bus.ocupado                  = ocupado;
   assign bus.carga_completa           = completa;

`ifdef CARGADOR_MASCARA_SUMA_EN
   logic [BITS_DATOS+4:0] suma_q, suma_d;

   // Sum restarts on an accepted start and holds once the last write is in
   always_comb begin
      suma_d = suma_q;
      if (inicio_ok)
         suma_d = '0;
      else if (escritura_q)
         suma_d = suma_q + (BITS_DATOS+5)'(bus.datos_mem);
   end

   // Sum register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) suma_q <= '0;
      else       suma_q <= suma_d;
   end

   assign suma_coeficientes = suma_q;
`endif

endmodule

// File: tb/tb_cargador_mascara.sv
// Directed bench for cargador_mascara with a scoreboard of expected reads,
// writes and completion pulses, each tagged with the cycle it must occur in.
module tb_cargador_mascara;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   all_ff = 1'b0;

   cargador_mascara_if #(.BITS_DIRECCION_MEM(10), .BITS_MASCARA(3), .BITS_DATOS(8)) bus ();

`ifdef CARGADOR_MASCARA_SUMA_EN
   logic [12:0] suma;
   cargador_mascara dut (.clk(clk), .reset(reset), .bus(bus), .suma_coeficientes(suma));
`else
   cargador_mascara dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   typedef struct {
      int         c;
      logic [9:0] addr;
      logic [4:0] idx;
      logic [7:0] dat;
   } ev_t;

   ev_t rd_q[$];
   ev_t wr_q[$];
   int  done_q[$];
   int  busy_from = -1;
   int  busy_to = -2;
   int  sum_exp = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem(input logic [9:0] a);
      return all_ff ? 8'hFF : a[7:0];
   endfunction

   // Memory model: one-cycle read latency
   always @(posedge clk)
      bus.datos_mem <= bus.habilitacion_lectura_mem ? mem(bus.direccion_lectura_mem) : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: every cycle outside reset, match DUT activity against the scoreboard
   always @(negedge clk) begin
      ev_t e;
      int  d;
      if (!reset) begin
         if (bus.habilitacion_lectura_mem) begin
            chk("rd_pending", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               chk("rd_cycle", 32'(cyc), 32'(e.c));
               chk("rd_addr", 32'(bus.direccion_lectura_mem), 32'(e.addr));
            end
         end else begin
            chk("rd_addr_idle", 32'(bus.direccion_lectura_mem), 32'd0);
         end
         if (bus.escritura_coeficiente) begin
            chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               chk("wr_cycle", 32'(cyc), 32'(e.c));
               chk("wr_idx", 32'(bus.direccion_coeficiente), 32'(e.idx));
               chk("wr_data", 32'(bus.dato_coeficiente), 32'(e.dat));
            end
         end else begin
            chk("wr_idx_idle", 32'(bus.direccion_coeficiente), 32'd0);
         end
         if (bus.carga_completa) begin
            chk("done_pending", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
               d = done_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(d));
            end
         end
         chk("ocupado", 32'(bus.ocupado), 32'((cyc >= busy_from) && (cyc <= busy_to)));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a start during the current cycle; legal sizes push the expected load
   task automatic start(input int size, input logic [9:0] base, input bit legal);
      int         n;
      int         c;
      logic [9:0] a;
      ev_t        e;
      bus.iniciar_carga = 1'b1;
      bus.tamano_mascara = 3'(size);
      bus.direccion_mem_inicio_mascara = base;
      if (legal) begin
         n = size * size;
         c = cyc;
         sum_exp = 0;
         for (int k = 0; k < n; k++) begin
            a = base + 10'(k);
            e.c = c + 1 + k; e.addr = a; e.idx = 5'(k); e.dat = mem(a);
            rd_q.push_back(e);
            e.c = c + 2 + k;
            wr_q.push_back(e);
            sum_exp += int'(mem(a));
         end
         done_q.push_back(c + n + 2);
         busy_from = c + 1;
         busy_to = c + n + 1;
      end
      step(1);
      bus.iniciar_carga = 1'b0;
      bus.tamano_mascara = 3'($urandom_range(0, 7));
      bus.direccion_mem_inicio_mascara = 10'($urandom);
   endtask

   // Start request that must be ignored (load in progress or in FIN)
   task automatic poke();
      bus.iniciar_carga = 1'b1;
      bus.tamano_mascara = 3'd5;
      bus.direccion_mem_inicio_mascara = 10'h2AA;
      step(1);
      bus.iniciar_carga = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(bus.habilitacion_lectura_mem), 32'd0);
      chk({tag, "_rd_addr"}, 32'(bus.direccion_lectura_mem), 32'd0);
      chk({tag, "_wr"}, 32'(bus.escritura_coeficiente), 32'd0);
      chk({tag, "_wr_idx"}, 32'(bus.direccion_coeficiente), 32'd0);
      chk({tag, "_wr_data"}, 32'(bus.dato_coeficiente), 32'd0);
      chk({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
      chk({tag, "_done"}, 32'(bus.carga_completa), 32'd0);
`ifdef CARGADOR_MASCARA_SUMA_EN
      chk({tag, "_suma"}, 32'(suma), 32'd0);
`endif
   endtask

   task automatic chk_sum(input string tag);
`ifdef CARGADOR_MASCARA_SUMA_EN
      chk(tag, 32'(suma), 32'(sum_exp));
`endif
   endtask

   initial begin
      reset = 1'b1;
      bus.iniciar_carga = 1'b0;
      bus.tamano_mascara = 3'd3;
      bus.direccion_mem_inicio_mascara = 10'h000;
      step(2);
      chk_all_zero("reset");

      // First start in the cycle reset is released: size 3, base 0x010
      reset = 1'b0;
      start(3, 10'h010, 1'b1);
      step(14);
      chk_sum("sum_size3");
      chk("sum_size3_value", 32'(sum_exp), 32'd180);

      // Size 5 with wrap of the read address past 0x3FF
      start(5, 10'h3FE, 1'b1);
      step(30);
      chk_sum("sum_wrap");

      // Illegal sizes: nothing may happen
      start(4, 10'h100, 1'b0);
      step(3);
      start(0, 10'h100, 1'b0);
      step(5);

      // Restarts in cycle 4 (LECTURA) and cycle 11 (FIN) are ignored
      start(3, 10'h100, 1'b1);
      step(3);
      poke();
      step(6);
      poke();
      step(6);
      chk_sum("sum_ignored");

      // Reset in cycle 5 of a size-5 load, then a fresh size-3 load
      start(5, 10'h020, 1'b1);
      step(4);
      #2 reset = 1'b1;
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      busy_from = -1;
      busy_to = -2;
      #1 chk_all_zero("midreset");
      step(1);
      reset = 1'b0;
      start(3, 10'h040, 1'b1);
      step(14);
      chk_sum("sum_after_reset");

      // All-0xFF coefficients, sum holds after completion
      all_ff = 1'b1;
      start(5, 10'h000, 1'b1);
      step(30);
      chk_sum("sum_ff");
      chk("sum_ff_value", 32'(sum_exp), 32'd6375);
      step(5);
      chk_sum("sum_ff_hold");

      chk("rd_left", 32'(rd_q.size()), 32'd0);
      chk("wr_left", 32'(wr_q.size()), 32'd0);
      chk("done_left", 32'(done_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
